// File: rtl/piso_arb_pkg.sv
// Shared types, default sizes and round-robin winner selection for piso_tx_arbiter.
package piso_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      GAP   = 2'd2
   } arb_state_t;

   localparam int unsigned DEF_WIDTH = 8;
   localparam int unsigned DEF_NREQ  = 4;
   localparam int unsigned MAX_NREQ  = 32;

   // First set bit of valid at or after ptr, wrapping modulo nreq; 0 when none is set.
   function automatic int unsigned rr_pick(input logic [MAX_NREQ-1:0] valid,
                                           input int unsigned         nreq,
                                           input int unsigned         ptr);
      int unsigned         idx;
      logic                found;
      logic [MAX_NREQ-1:0] sh;
      rr_pick = 0;
      found   = 1'b0;
      for (int unsigned off = 0; off < MAX_NREQ; off++) begin
         idx = (ptr + off) % nreq;
         sh  = valid >> idx;
         if (!found && (off < nreq) && sh[0]) begin
            rr_pick = idx;
            found   = 1'b1;
         end
      end
   endfunction

endpackage

// File: rtl/piso_shifter.sv
// Parallel-load, LSB-first right shifter with zero fill; bit 0 is the serial tap.
module piso_shifter #(
   parameter int WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_i,
   input  logic             shift_en_i,
   input  logic [WIDTH-1:0] din_i,
   output logic             bit0_o
);

   logic [WIDTH-1:0] sh_q;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         sh_q <= '0;
      end else if (load_i) begin
         sh_q <= din_i;
      end else if (shift_en_i) begin
         sh_q <= {1'b0, sh_q[WIDTH-1:1]};
      end
   end

   assign bit0_o = sh_q[0];

endmodule

// File: rtl/piso_tx_arbiter.sv
// Round-robin arbiter feeding one shared PISO serial line with framing strobes.
// Optional even-parity trailer bit: define PISO_ARB_PARITY_EN.
//
// state | meaning
// IDLE  | arbitrate, accept one word, load the shifter
// SHIFT | drive frame bits (data, then parity when enabled)
// GAP   | one-cycle inter-frame spacer, line quiet
module piso_tx_arbiter
   import piso_arb_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int NREQ  = DEF_NREQ,
   localparam int GW   = $clog2(NREQ)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [NREQ*WIDTH-1:0] req_data,
   output logic [NREQ-1:0]       req_ready,
   output logic                  ser_out,
   output logic                  ser_valid,
   output logic                  ser_first,
   output logic [GW-1:0]         grant_id,
   output logic                  busy
);

   localparam int CW = $clog2(WIDTH + 2);
`ifdef PISO_ARB_PARITY_EN
   localparam int F = WIDTH + 1;
`else
   localparam int F = WIDTH;
`endif
   localparam logic [CW-1:0] LAST = CW'(F - 1);

   arb_state_t       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [GW-1:0]    rr_q, rr_d;
   logic [GW-1:0]    grant_q, grant_d;
   logic             ser_valid_q, ser_valid_d;
   logic             ser_first_q, ser_first_d;
   logic             busy_q, busy_d;
   logic             any_valid;
   logic [GW-1:0]    win;
   logic [GW-1:0]    rr_nxt;
   logic [WIDTH-1:0] win_word;
   logic             load;
   logic             shift_en;
   logic             sh_bit0;

   assign any_valid = |req_valid;
   assign win       = GW'(rr_pick(MAX_NREQ'(req_valid), NREQ, 32'(rr_q)));
   assign rr_nxt    = (win == GW'(NREQ - 1)) ? '0 : win + GW'(1);
   assign win_word  = req_data[win*WIDTH +: WIDTH];

   always_comb begin
      req_ready = '0;
      if (rst && (state_q == IDLE) && any_valid) begin
         req_ready[win] = 1'b1;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rr_d        = rr_q;
      grant_d     = grant_q;
      ser_valid_d = 1'b0;
      ser_first_d = 1'b0;
      busy_d      = 1'b0;
      load        = 1'b0;
      shift_en    = 1'b0;
      case (state_q)
         IDLE: begin
            if (any_valid) begin
               load        = 1'b1;
               state_d     = SHIFT;
               cnt_d       = '0;
               rr_d        = rr_nxt;
               grant_d     = win;
               ser_valid_d = 1'b1;
               ser_first_d = 1'b1;
               busy_d      = 1'b1;
            end
         end
         SHIFT: begin
            shift_en = 1'b1;
            busy_d   = 1'b1;
            if (cnt_q == LAST) begin
               state_d = GAP;
            end else begin
               cnt_d       = cnt_q + CW'(1);
               ser_valid_d = 1'b1;
            end
         end
         GAP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         rr_q        <= '0;
         grant_q     <= '0;
         ser_valid_q <= 1'b0;
         ser_first_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rr_q        <= rr_d;
         grant_q     <= grant_d;
         ser_valid_q <= ser_valid_d;
         ser_first_q <= ser_first_d;
         busy_q      <= busy_d;
      end
   end

   piso_shifter #(.WIDTH(WIDTH)) u_shifter (
      .clk_i      (clk),
      .rst_i      (rst),
      .load_i     (load),
      .shift_en_i (shift_en),
      .din_i      (win_word),
      .bit0_o     (sh_bit0)
   );

`ifdef PISO_ARB_PARITY_EN
   localparam logic [CW-1:0] PAR_CNT = CW'(WIDTH - 1);
   logic par_word_q;
   logic par_q;

   // The shifter is all zeros by the parity slot, so OR-ing the parity flop in is clean.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         par_word_q <= 1'b0;
         par_q      <= 1'b0;
      end else begin
         if (load) begin
            par_word_q <= ^win_word;
         end
         par_q <= ((state_q == SHIFT) && (cnt_q == PAR_CNT)) ? par_word_q : 1'b0;
      end
   end

   assign ser_out = sh_bit0 | par_q;
`else
   assign ser_out = sh_bit0;
`endif

   assign ser_valid = ser_valid_q;
   assign ser_first = ser_first_q;
   assign grant_id  = grant_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_piso_tx_arbiter.sv
// Scoreboard bench for piso_tx_arbiter: frame bits queued at each handshake, popped as they appear.
module tb_piso_tx_arbiter;

   localparam int WIDTH = 8;
   localparam int NREQ  = 4;
   localparam int GW    = 2;
`ifdef PISO_ARB_PARITY_EN
   localparam int F = WIDTH + 1;
`else
   localparam int F = WIDTH;
`endif

   logic                  clk = 1'b0;
   logic                  rst = 1'b0;
   logic [NREQ-1:0]       req_valid = '0;
   logic [NREQ*WIDTH-1:0] req_data = '0;
   logic [NREQ-1:0]       req_ready;
   logic                  ser_out;
   logic                  ser_valid;
   logic                  ser_first;
   logic [GW-1:0]         grant_id;
   logic                  busy;

   piso_tx_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .ser_out   (ser_out),
      .ser_valid (ser_valid),
      .ser_first (ser_first),
      .grant_id  (grant_id),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic          b;
      logic          first;
      logic [GW-1:0] gid;
   } exp_t;

   exp_t sb[$];
   int   glog[$];
   int   n_cmp = 0;
   int   n_err = 0;
   logic mon_en = 1'b0;
   int   m_rr = 0;
   int   m_busy = 0;

   // Per-requester word FIFOs (circular, 8 deep)
   logic [WIDTH-1:0] wmem [NREQ][8];
   int               wrd [NREQ];
   int               wwr [NREQ];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int m_pick(input logic [NREQ-1:0] v, input int p);
      for (int k = 0; k < NREQ; k++) begin
         if (v[(p + k) % NREQ]) return (p + k) % NREQ;
      end
      return -1;
   endfunction

   function automatic int pend();
      int s = 0;
      for (int i = 0; i < NREQ; i++) s += wwr[i] - wrd[i];
      return s;
   endfunction

   task automatic push(input int r, input logic [WIDTH-1:0] w);
      wmem[r][wwr[r] % 8] = w;
      wwr[r]++;
   endtask

   // Requester driver: present the head of each FIFO, hold until accepted.
   always @(posedge clk) begin
      #1;
      for (int i = 0; i < NREQ; i++) begin
         req_valid[i]                = (wrd[i] != wwr[i]);
         req_data[i*WIDTH +: WIDTH]  = wmem[i][wrd[i] % 8];
      end
   end

   int               w;
   logic [NREQ-1:0]  exp_rdy;
   logic [WIDTH-1:0] word;
   exp_t             e;

   always @(negedge clk) begin
      if (mon_en) begin
         if (m_busy > 0) begin
            chk("busy", 32'(busy), 32'(1));
            chk("ready_busy", 32'(req_ready), 32'(0));
            if (m_busy > 1) begin
               chk("ser_valid", 32'(ser_valid), 32'(1));
               if (sb.size() > 0) begin
                  e = sb.pop_front();
                  chk("ser_out", 32'(ser_out), 32'(e.b));
                  chk("ser_first", 32'(ser_first), 32'(e.first));
                  chk("grant_id", 32'(grant_id), 32'(e.gid));
               end
            end else begin
               chk("gap_valid", 32'(ser_valid), 32'(0));
               chk("gap_out", 32'(ser_out), 32'(0));
            end
            m_busy--;
         end else begin
            chk("idle_busy", 32'(busy), 32'(0));
            chk("idle_valid", 32'(ser_valid), 32'(0));
            chk("idle_first", 32'(ser_first), 32'(0));
            chk("idle_out", 32'(ser_out), 32'(0));
            exp_rdy = '0;
            w = m_pick(req_valid, m_rr);
            if (w >= 0) exp_rdy[w] = 1'b1;
            chk("req_ready", 32'(req_ready), 32'(exp_rdy));
            if (w >= 0) begin
               word = wmem[w][wrd[w] % 8];
               for (int k = 0; k < WIDTH; k++)
                  sb.push_back('{b: word[k], first: (k == 0), gid: GW'(w)});
               if (F > WIDTH) sb.push_back('{b: ^word, first: 1'b0, gid: GW'(w)});
               m_rr   = (w + 1) % NREQ;
               m_busy = F + 1;
            end
            for (int i = 0; i < NREQ; i++) begin
               if (req_ready[i] && req_valid[i]) begin
                  glog.push_back(i);
                  wrd[i]++;
               end
            end
         end
      end
   end

   task automatic drain();
      int c = 0;
      while (c < 400 && !(pend() == 0 && m_busy == 0)) begin
         @(negedge clk);
         #1;
         c++;
      end
      chk("drain_pending", 32'(pend() + m_busy), 32'(0));
   endtask

   task automatic chk_order(input string tag, input int n, input int ex [8]);
      chk({tag, "_len"}, 32'(glog.size()), 32'(n));
      for (int i = 0; i < n; i++) begin
         if (i < glog.size()) chk(tag, 32'(glog[i]), 32'(ex[i]));
      end
   endtask

   task automatic model_reset();
      sb.delete();
      m_busy = 0;
      m_rr   = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int ord[8];
      int c;
      for (int i = 0; i < NREQ; i++) begin
         wrd[i] = 0;
         wwr[i] = 0;
      end

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ser_out", 32'(ser_out), 32'(0));
      chk("rst_ser_valid", 32'(ser_valid), 32'(0));
      chk("rst_ser_first", 32'(ser_first), 32'(0));
      chk("rst_grant_id", 32'(grant_id), 32'(0));
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_ready", 32'(req_ready), 32'(0));
      rst    = 1'b1;
      mon_en = 1'b1;
      repeat (5) @(negedge clk);

      // Single request from requester 2, word B5
      glog.delete();
      push(2, 8'hB5);
      drain();
      ord = '{2, 0, 0, 0, 0, 0, 0, 0};
      chk_order("single_grant", 1, ord);

      // All four requesters pending across reset release
      @(posedge clk);
      #1;
      mon_en = 1'b0;
      rst    = 1'b0;
      model_reset();
      for (int r = 0; r < NREQ; r++) begin
         push(r, 8'(8'h11 * (r + 1)));
         push(r, 8'(8'hA0 + r));
      end
      repeat (2) @(posedge clk);
      #1;
      rst    = 1'b1;
      mon_en = 1'b1;
      glog.delete();
      drain();
      ord = '{0, 1, 2, 3, 0, 1, 2, 3};
      chk_order("rr_all", 8, ord);

      // Steer rr_ptr to 2, then requesters 1 and 3 together
      push(1, 8'h0F);
      drain();
      glog.delete();
      push(1, 8'hC3);
      push(3, 8'h7E);
      drain();
      ord = '{3, 1, 0, 0, 0, 0, 0, 0};
      chk_order("rr_skip", 2, ord);

      // Reset during the 4th bit of a frame
      push(2, 8'h3C);
      c = 0;
      do begin
         @(negedge clk);
         c++;
      end while (!ser_first && c < 50);
      chk("wait_first", 32'(ser_first), 32'(1));
      push(0, 8'h96);
      push(3, 8'h5A);
      repeat (3) @(negedge clk);
      #2;
      mon_en = 1'b0;
      rst    = 1'b0;
      #1;
      chk("abort_ser_valid", 32'(ser_valid), 32'(0));
      chk("abort_busy", 32'(busy), 32'(0));
      chk("abort_ser_out", 32'(ser_out), 32'(0));
      chk("abort_ready", 32'(req_ready), 32'(0));
      chk("abort_grant_id", 32'(grant_id), 32'(0));
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst    = 1'b1;
      mon_en = 1'b1;
      glog.delete();
      drain();
      ord = '{0, 3, 0, 0, 0, 0, 0, 0};
      chk_order("post_abort", 2, ord);

      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/piso_tx_arbiter.md
# piso_tx_arbiter

Round-robin scheduler that shares one parallel-in/serial-out shift datapath among NREQ requesters. It accepts one parallel word per handshake and drives it out LSB-first on a single serial line with framing strobes. Frames are separated by a one-cycle idle gap. It sits between the parallel producers and the serial link driver.

## Interface

- WIDTH, 8, data bits per word; legal range ≥ 2.
- NREQ, 4, number of requesters; legal range ≥ 2.
- GW, $clog2(NREQ), derived localparam: grant index width.

- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-low.
- req_valid  input  NREQ  bit i high means requester i offers a word.
- req_data  input  NREQ*WIDTH  word i occupies bits [i*WIDTH +: WIDTH].
- req_ready  output  NREQ  one-hot acceptance strobe; combinational.
- ser_out  output  1  serial data bit, registered.
- ser_valid  output  1  high while ser_out carries a frame bit, registered.
- ser_first  output  1  high with the first bit of each frame, registered.
- grant_id  output  GW  index of the requester whose frame is on the line, registered.
- busy  output  1  high in SHIFT and GAP, registered.

## Operation

- States:
  - IDLE: accepts a new word.
  - SHIFT: drives frame bits.
  - GAP: one-cycle inter-frame spacer.
- IDLE behaviour:
  - If any req_valid bit is high, the arbiter picks winner g.
  - The search starts at rr_ptr and wraps modulo NREQ.
  - req_ready[g] is 1 for that cycle only. All other req_ready bits are 0.
  - Handshake is req_valid[g] & req_ready[g].
  - On the clock edge ending the handshake cycle:
    - the shifter loads req_data[g]
    - grant_id <= g
    - rr_ptr <= (g+1) mod NREQ
    - state moves to SHIFT.
  - If no req_valid bit is high, the block stays in IDLE and rr_ptr is unchanged.
- SHIFT behaviour:
  - Outputs bit 0 first.
  - Each cycle the shifter moves right one position, filling with 0.
  - After WIDTH data bits (plus the parity bit when enabled), the next state is GAP.
- GAP behaviour:
  - ser_valid=0, ser_out=0, busy=1.
  - Next state is always IDLE.
- req_ready is 0 in every state other than IDLE.
- Requester obligations (not checked by this block):
  - Hold req_valid and req_data stable until accepted.
  - Do not withdraw valid before the handshake.
- A deasserted req_valid simply removes that requester from the current arbitration.

## Timing

- Reset values (asynchronous, active while rst=0):
  - State=IDLE.
  - ser_out=0, ser_valid=0, ser_first=0, grant_id=0, busy=0.
  - rr_ptr=0.
  - Shifter cleared.
  - req_ready=0 (rst gates the combinational path).
- Frame timing, with the handshake in cycle N:
  - Bit k is on ser_out in cycle N+1+k, for k=0..WIDTH-1, with ser_valid=1.
  - ser_first=1 only in cycle N+1.
  - GAP occupies cycle N+1+F, where F is the frame length.
  - IDLE is reached at cycle N+2+F, the earliest possible next handshake.
- Throughput: one word per F+2 cycles. F = WIDTH, or WIDTH+1 with parity enabled.
- Simultaneous requests: exactly one winner per IDLE cycle; losers keep waiting.
- Continuous requests from all requesters are granted in the order rr_ptr, rr_ptr+1, …, wrapping from NREQ-1 to 0.
- Reset asserted mid-frame:
  - The frame aborts immediately.
  - All outputs take their reset values in the same instant.
  - The word is lost and no further bits are emitted.
  - rr_ptr returns to 0.
- Reset deassertion: the first handshake is possible on the first clock edge after rst rises.

## Configuration

- Macro: PISO_ARB_PARITY_EN.
- Defined:
  - After bit WIDTH-1, one extra bit is driven with ser_valid=1.
  - Its value is the even parity of the word, i.e. the XOR of all WIDTH bits, captured at load.
  - F = WIDTH+1.
- Undefined:
  - No parity logic is built.
  - F = WIDTH.

## Structure

- Package piso_arb_pkg holds:
  - state enum: IDLE, SHIFT, GAP.
  - default WIDTH and NREQ constants.
  - the function that computes round-robin winner selection from the valid vector and rr_ptr.
- Sub-module piso_shifter:
  - Contents: WIDTH-bit register.
  - Controls: load and shift_en inputs.
  - Behaviour: LSB-first shift right with 0 fill; exposes bit 0.
  - Asynchronous active-low clear.
- The top level holds the FSM, the bit counter (width $clog2(WIDTH+2)), the arbiter, and the output registers.

## Test plan

- Reset while idle, then release; req_valid=4'b0000 for 5 cycles → all outputs 0, req_ready=0, busy=0.
- Single request, WIDTH=8, req_valid=4'b0100, req_data word2=8'hB5 → req_ready=4'b0100 in the handshake cycle; ser_out sequence 1,0,1,0,1,1,0,1; ser_first only on the first bit; grant_id=2; one gap cycle; IDLE after 10 cycles.
- All four requesters continuously valid from reset → grant order 0,1,2,3,0; each frame separated by exactly one ser_valid=0 cycle.
- Requesters 1 and 3 valid with rr_ptr=2 → 3 granted first, then 1.
- Reset pulsed during the 4th bit of a frame → ser_valid and busy drop asynchronously; after release, rr_ptr=0 and a pending requester 0 wins.
- With PISO_ARB_PARITY_EN and word 8'hB5 → ninth bit is 1 with ser_valid=1; next handshake possible 11 cycles after the previous one.
